smm_product_accumulator: RTL and testbench
==========================================

SMM_PRODUCT_ACCUMULATOR -- requirements
Module: smm_product_accumulator

Interface
REQ-001 Parameter: K, default 25, number of products summed per result; legal range 2..65535.
REQ-002 Parameter: PROD_WIDTH, default 64, product width, unsigned.
REQ-003 Parameter: ACC_WIDTH, default 72, accumulator/result width; SHALL be at least PROD_WIDTH+ceil(log2 K), checked at elaboration.
REQ-004 Ports: ap_clk  in  1  sole clock, rising edge.
REQ-005 Ports: ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports: clear  in  1  synchronous abort of the partial sum in progress.
REQ-007 Ports: prod_valid  in  1  prod_data is valid.
REQ-008 Ports: prod_data  in  PROD_WIDTH  unsigned product from the registered 2-stage multiplier.
REQ-009 Ports: prod_ready  out  1  accumulator accepts prod_data this cycle.
REQ-010 Ports: acc_valid  out  1  acc_data holds a completed sum.
REQ-011 Ports: acc_data  out  ACC_WIDTH  completed unsigned sum of K products.
REQ-012 Ports: acc_ready  in  1  downstream consumes acc_data.
REQ-013 Ports: busy  out  1  a partial sum is in progress (term count nonzero).

Function
REQ-014 Product transfer occurs on a rising edge with prod_valid=1 and prod_ready=1; result transfer occurs on an edge with acc_valid=1 and acc_ready=1.
REQ-015 Internal state: partial-sum register sum (ACC_WIDTH), term counter cnt (0..K-1), and output register (acc_data/acc_valid), so accumulation of the next dot product overlaps a held result.
REQ-016 States: ACCUM (cnt<K-1 or output free) and STALL (cnt=K-1, acc_valid=1, acc_ready=0); there is no other state.
REQ-017 prod_ready SHALL be 1 except: 0 while in STALL, and 0 in the cycle clear=1.
REQ-018 Non-final transfer (cnt<K-1): sum <= sum + zero-extended prod_data; cnt <= cnt+1.
REQ-019 Final transfer (cnt=K-1): acc_data <= sum + prod_data; acc_valid <= 1; sum <= 0; cnt <= 0; result is visible one cycle after the final transfer edge.
REQ-020 A final transfer and a result transfer on the same edge SHALL both occur; acc_valid stays 1 with the new acc_data (no bubble, no loss).
REQ-021 Result transfer without a new final transfer: acc_valid <= 0; acc_data holds its last value.
REQ-022 acc_valid=1 with acc_ready=0 SHALL hold acc_data and acc_valid stable.
REQ-023 Addition is full-width unsigned; no wrap, no saturation, no truncation within the legal parameter range.
REQ-024 clear=1: sum <= 0, cnt <= 0, no product accepted that edge (prod_valid ignored); output register and pending result unaffected.
REQ-025 busy = (cnt != 0), combinational from registered cnt.
REQ-026 prod_ready SHALL not depend combinationally on prod_valid; it may depend on acc_ready.

Reset
REQ-027 ap_rst_n=0 SHALL asynchronously force sum=0, cnt=0, acc_valid=0, acc_data=0; outputs prod_ready=0 and busy=0 while ap_rst_n=0.
REQ-028 Reset mid-sum SHALL discard the partial sum; the first transfer after release starts a new sum at term 0.
REQ-029 Reset release is taken synchronously by the instantiating design; prod_ready SHALL be 1 on the first edge after release.

Verification
REQ-030 K=4, acc_ready=1, products 1,2,3,4 on consecutive cycles -> acc_valid=1, acc_data=10 the cycle after the 4th transfer, for exactly one cycle; busy 1 for 3 cycles.
REQ-031 K=4, ACC_WIDTH=66, four products 0xFFFF_FFFF_FFFF_FFFF -> acc_data=0x3_FFFF_FFFF_FFFF_FFFC, no overflow.
REQ-032 K=4, acc_ready=0, stream 1..8 continuously -> first result 10 held; prod_ready drops at 8th term (cnt=3); raising acc_ready releases 10 and next cycle acc_data=26 with no gap.
REQ-033 K=4, acc_ready=1, products 5,6 then clear=1 with prod_valid=1 data 99, then 1,1,1,1 -> single result acc_data=4; 99 not accepted.
REQ-034 K=4, after 2 transfers assert ap_rst_n=0 mid-cycle -> acc_valid, busy, prod_ready fall immediately; after release 2,2,2,2 -> acc_data=8.
REQ-035 Random valid/ready toggling, 1000 sums, K=25 -> every result equals scoreboard sum of its 25 accepted products, in order, none lost or duplicated.

Source files
------------

// File: rtl/smm_product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the product accumulator
// and the downstream consumer of completed dot-product sums.
interface smm_product_accumulator_if #(
    parameter int unsigned PROD_WIDTH = 64,
    parameter int unsigned ACC_WIDTH  = 72
);
    logic                  clear;
    logic                  prod_valid;
    logic [PROD_WIDTH-1:0] prod_data;
    logic                  prod_ready;
    logic                  acc_valid;
    logic [ACC_WIDTH-1:0]  acc_data;
    logic                  acc_ready;
    logic                  busy;

    // Producer/consumer side: drives products and acc_ready, observes results.
    modport master (
        output clear,
        output prod_valid,
        output prod_data,
        input  prod_ready,
        input  acc_valid,
        input  acc_data,
        output acc_ready,
        input  busy
    );

    // Accumulator side.
    modport slave (
        input  clear,
        input  prod_valid,
        input  prod_data,
        output prod_ready,
        output acc_valid,
        output acc_data,
        input  acc_ready,
        output busy
    );
endinterface

// File: rtl/smm_product_accumulator.sv
// Sums K unsigned products per result; the output register holds one finished sum
// while the next dot product accumulates behind it.
module smm_product_accumulator #(
    parameter int unsigned K          = 25,
    parameter int unsigned PROD_WIDTH = 64,
    parameter int unsigned ACC_WIDTH  = 72
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    smm_product_accumulator_if.slave    bus
);

    localparam int unsigned    CNT_W = $clog2(K);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    generate
        if (K < 2 || K > 65535) begin : g_bad_k
            $error("smm_product_accumulator: K must be in 2..65535");
        end
        if (ACC_WIDTH < PROD_WIDTH + $clog2(K)) begin : g_bad_acc_width
            $error("smm_product_accumulator: ACC_WIDTH too narrow for K products");
        end
    endgenerate

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [ACC_WIDTH-1:0]   sum_p0;
    logic [ACC_WIDTH-1:0]   sum_nxt;
    logic [CNT_W-1:0]       cnt_p0;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [ACC_WIDTH-1:0]   acc_p1;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic                   vld_p1;
    logic                   vld_nxt;
    logic                   prod_ready;
    logic                   accept;
    logic                   last_term;
    logic                   res_take;

    function automatic logic [ACC_WIDTH-1:0] add_term(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [PROD_WIDTH-1:0] prod
    );
        return acc + ACC_WIDTH'(prod);
    endfunction

    // STALL means the last term is due while the output still holds a result; it
    // only blocks input while the consumer is not taking that result this cycle.
    assign prod_ready = ap_rst_n & ~bus.clear & ~((state_q == STALL) & ~bus.acc_ready);
    assign accept     = bus.prod_valid & prod_ready;
    assign last_term  = (cnt_p0 == LAST);
    assign res_take   = vld_p1 & bus.acc_ready;

    always_comb begin
        sum_nxt = sum_p0;
        cnt_nxt = cnt_p0;
        acc_nxt = acc_p1;
        vld_nxt = vld_p1;
        state_d = state_q;

        if (bus.clear) begin
            sum_nxt = '0;
            cnt_nxt = '0;
        end else if (accept) begin
            if (last_term) begin
                acc_nxt = add_term(sum_p0, bus.prod_data);
                sum_nxt = '0;
                cnt_nxt = '0;
            end else begin
                sum_nxt = add_term(sum_p0, bus.prod_data);
                cnt_nxt = cnt_p0 + CNT_W'(1);
            end
        end

        // A new result replaces one leaving on the same edge, so no bubble appears.
        if (accept && last_term) begin
            vld_nxt = 1'b1;
        end else if (res_take) begin
            vld_nxt = 1'b0;
        end

        state_d = ((cnt_nxt == LAST) && vld_nxt) ? STALL : ACCUM;
    end

    // Stage p0: partial sum and term counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sum_p0  <= '0;
            cnt_p0  <= '0;
            state_q <= ACCUM;
        end else begin
            sum_p0  <= sum_nxt;
            cnt_p0  <= cnt_nxt;
            state_q <= state_d;
        end
    end

    // Stage p1: held result register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            acc_p1 <= acc_nxt;
            vld_p1 <= vld_nxt;
        end
    end

    assign bus.prod_ready = prod_ready;
    assign bus.acc_valid  = vld_p1;
    assign bus.acc_data   = acc_p1;
    assign bus.busy       = (cnt_p0 != '0);

endmodule

// File: tb/tb_smm_product_accumulator.sv
// Bench: directed K=4 scenarios plus a randomized K=25 run against a queue-based
// scoreboard of accepted products.
module tb_smm_product_accumulator;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    smm_product_accumulator_if #(.PROD_WIDTH(64), .ACC_WIDTH(66)) if4 ();
    smm_product_accumulator_if #(.PROD_WIDTH(64), .ACC_WIDTH(72)) if25 ();

    smm_product_accumulator #(.K(4), .PROD_WIDTH(64), .ACC_WIDTH(66)) dut4 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (if4.slave)
    );

    smm_product_accumulator #(.K(25), .PROD_WIDTH(64), .ACC_WIDTH(72)) dut25 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (if25.slave)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of K=4 stimulus at the falling edge, then settle just before
    // the rising edge so checks see the state left by the previous edge.
    task automatic step4(input logic pv, input logic [63:0] pd, input logic ar, input logic clr);
        @(negedge ap_clk);
        if4.prod_valid = pv;
        if4.prod_data  = pd;
        if4.acc_ready  = ar;
        if4.clear      = clr;
        #4;
    endtask

    localparam logic [63:0] ONES = {64{1'b1}};

    logic [63:0] prods[$];
    logic [71:0] expq[$];
    logic [71:0] s;
    logic [71:0] e;
    int          nres;
    int          cyc;

    initial begin
        if4.clear = 0;  if4.prod_valid = 0;  if4.prod_data = '0;  if4.acc_ready = 1;
        if25.clear = 0; if25.prod_valid = 0; if25.prod_data = '0; if25.acc_ready = 1;

        // Reset state
        #2;
        chk("rst_ready4", if4.prod_ready, 0);
        chk("rst_busy4", if4.busy, 0);
        chk("rst_valid4", if4.acc_valid, 0);
        chk("rst_data4", if4.acc_data, 0);
        chk("rst_ready25", if25.prod_ready, 0);
        chk("rst_valid25", if25.acc_valid, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        chk("rel_ready4", if4.prod_ready, 1);

        // Basic sum 1+2+3+4
        for (int i = 1; i <= 4; i++) begin
            step4(1, 64'(i), 1, 0);
            chk("basic_ready", if4.prod_ready, 1);
            chk("basic_busy", if4.busy, (i > 1) ? 1 : 0);
        end
        step4(0, 0, 1, 0);
        chk("basic_busy_end", if4.busy, 0);
        chk("basic_valid", if4.acc_valid, 1);
        chk("basic_data", if4.acc_data, 10);
        step4(0, 0, 1, 0);
        chk("basic_valid_once", if4.acc_valid, 0);

        // Full-width sum of maximal products
        for (int i = 0; i < 4; i++) step4(1, ONES, 1, 0);
        step4(0, 0, 1, 0);
        chk("wide_valid", if4.acc_valid, 1);
        chk("wide_data", if4.acc_data, 66'h3_FFFF_FFFF_FFFF_FFFC);
        step4(0, 0, 1, 0);

        // Backpressure: stream 1..8 with acc_ready low
        for (int i = 1; i <= 7; i++) begin
            step4(1, 64'(i), 0, 0);
            chk("bp_ready", if4.prod_ready, 1);
        end
        step4(1, 8, 0, 0);
        chk("bp_stall", if4.prod_ready, 0);
        chk("bp_hold_v", if4.acc_valid, 1);
        chk("bp_hold_d", if4.acc_data, 10);
        step4(1, 8, 0, 0);
        chk("bp_stall2", if4.prod_ready, 0);
        chk("bp_hold_d2", if4.acc_data, 10);
        step4(1, 8, 1, 0);
        chk("bp_release", if4.prod_ready, 1);
        chk("bp_first", if4.acc_data, 10);
        step4(0, 0, 0, 0);
        chk("bp_nogap_v", if4.acc_valid, 1);
        chk("bp_second", if4.acc_data, 26);
        step4(0, 0, 1, 0);
        step4(0, 0, 1, 0);
        chk("bp_drained", if4.acc_valid, 0);

        // Clear aborts a partial sum and refuses the product offered with it
        step4(1, 5, 1, 0);
        step4(1, 6, 1, 0);
        step4(1, 99, 1, 1);
        chk("clr_ready", if4.prod_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step4(1, 1, 1, 0);
            if (i == 0) chk("clr_busy", if4.busy, 0);
        end
        step4(0, 0, 1, 0);
        chk("clr_valid", if4.acc_valid, 1);
        chk("clr_data", if4.acc_data, 4);
        step4(0, 0, 1, 0);
        chk("clr_once", if4.acc_valid, 0);

        // Asynchronous reset in the middle of a sum with a result pending
        for (int i = 0; i < 4; i++) step4(1, 1, 0, 0);
        step4(1, 9, 0, 0);
        step4(1, 9, 0, 0);
        step4(0, 0, 0, 0);
        chk("mid_busy", if4.busy, 1);
        chk("mid_valid", if4.acc_valid, 1);
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_valid", if4.acc_valid, 0);
        chk("arst_busy", if4.busy, 0);
        chk("arst_ready", if4.prod_ready, 0);
        chk("arst_data", if4.acc_data, 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step4(1, 2, 1, 0);
            chk("post_rst_ready", if4.prod_ready, 1);
        end
        step4(0, 0, 1, 0);
        chk("post_rst_valid", if4.acc_valid, 1);
        chk("post_rst_data", if4.acc_data, 8);
        step4(0, 0, 1, 0);

        // Randomized K=25 run with a scoreboard of accepted products
        nres = 0;
        cyc  = 0;
        while (nres < 1000 && cyc < 90000) begin
            @(negedge ap_clk);
            cyc++;
            if25.prod_valid = ($urandom_range(3) != 0);
            if25.prod_data  = ($urandom_range(7) == 0) ? ONES : {$urandom, $urandom};
            if25.acc_ready  = ($urandom_range(3) != 0);
            if25.clear      = ($urandom_range(199) == 0);
            #4;
            if (if25.acc_valid && if25.acc_ready) begin
                if (expq.size() == 0) begin
                    chk("rnd_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_result", if25.acc_data, e);
                end
                nres++;
            end
            if (if25.clear) begin
                chk("rnd_clr_ready", if25.prod_ready, 0);
                prods.delete();
            end else if (if25.prod_valid && if25.prod_ready) begin
                prods.push_back(if25.prod_data);
                if (prods.size() == 25) begin
                    s = '0;
                    foreach (prods[i]) s = s + 72'(prods[i]);
                    expq.push_back(s);
                    prods.delete();
                end
            end
        end
        if25.prod_valid = 0;
        if25.clear      = 0;
        chk("rnd_count", nres, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
